// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch unit: ROM handshake, two-word assembly, 2-entry buffer
module instr_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_cs,
  output logic [15:0] rom_addr,
  input  logic        rom_ready,
  input  logic [15:0] rom_data,
  output logic        instr_valid,
  output logic [15:0] instr_op,
  output logic [15:0] instr_operand,
  output logic [15:0] instr_pc,
  input  logic        instr_accept,
  input  logic        redirect,
  input  logic [15:0] redirect_pc
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_WAIT_LO = 2'd2;
  localparam logic [1:0] S_WAIT_HI = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic        discard_q, discard_d;
  logic        have_op_q, have_op_d;
  logic [15:0] op_q, op_d, op_pc_q, op_pc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] e0_op_q, e0_op_d, e0_opnd_q, e0_opnd_d, e0_pc_q, e0_pc_d;
  logic [15:0] e1_op_q, e1_op_d, e1_opnd_q, e1_opnd_d, e1_pc_q, e1_pc_d;
  logic        rom_cs_q, rom_cs_d;
  logic [15:0] rom_addr_q, rom_addr_d;

  logic capture, drop, push, pop;

  // A word completing while a redirect is pending or arriving belongs to the old stream.
  assign capture = (state_q == S_WAIT_HI) && rom_ready;
  assign drop    = capture && (discard_q || redirect);
  assign push    = capture && !drop && have_op_q;
  assign pop     = (cnt_q != 2'd0) && instr_accept;

  always_comb begin
    cnt_d     = cnt_q;
    e0_op_d   = e0_op_q;
    e0_opnd_d = e0_opnd_q;
    e0_pc_d   = e0_pc_q;
    e1_op_d   = e1_op_q;
    e1_opnd_d = e1_opnd_q;
    e1_pc_d   = e1_pc_q;
    if (redirect) begin
      cnt_d = 2'd0;
    end else if (push && !pop) begin
      if (cnt_q == 2'd0) begin
        e0_op_d = op_q; e0_opnd_d = rom_data; e0_pc_d = op_pc_q;
      end else begin
        e1_op_d = op_q; e1_opnd_d = rom_data; e1_pc_d = op_pc_q;
      end
      cnt_d = cnt_q + 2'd1;
    end else if (pop && !push) begin
      e0_op_d = e1_op_q; e0_opnd_d = e1_opnd_q; e0_pc_d = e1_pc_q;
      cnt_d   = cnt_q - 2'd1;
    end else if (push && pop) begin
      if (cnt_q == 2'd1) begin
        e0_op_d = op_q; e0_opnd_d = rom_data; e0_pc_d = op_pc_q;
      end else begin
        e0_op_d = e1_op_q; e0_opnd_d = e1_opnd_q; e0_pc_d = e1_pc_q;
        e1_op_d = op_q; e1_opnd_d = rom_data; e1_pc_d = op_pc_q;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    discard_d = discard_q;
    have_op_d = have_op_q;
    op_d      = op_q;
    op_pc_d   = op_pc_q;
    case (state_q)
      S_IDLE: begin
        if (cnt_q != 2'd2 && !redirect) state_d = S_REQ;
      end
      S_REQ: begin
        state_d = S_WAIT_LO;
        if (redirect) discard_d = 1'b1;
      end
      S_WAIT_LO: begin
        if (redirect) discard_d = 1'b1;
        if (!rom_ready) state_d = S_WAIT_HI;
      end
      default: begin
        if (redirect) discard_d = 1'b1;
        if (rom_ready) begin
          if (drop) begin
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else begin
            pc_d = pc_q + 16'd1;
            if (!have_op_q) begin
              op_d      = rom_data;
              op_pc_d   = pc_q;
              have_op_d = 1'b1;
              state_d   = S_REQ;
            end else begin
              have_op_d = 1'b0;
              state_d   = (cnt_d != 2'd2) ? S_REQ : S_IDLE;
            end
          end
        end
      end
    endcase
    if (redirect) begin
      pc_d      = redirect_pc;
      have_op_d = 1'b0;
    end
  end

  // Address is only loaded when entering REQ, so it holds through the whole handshake.
  assign rom_cs_d   = (state_d == S_REQ);
  assign rom_addr_d = (state_d == S_REQ) ? pc_d : rom_addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      discard_q  <= 1'b0;
      have_op_q  <= 1'b0;
      op_q       <= 16'h0000;
      op_pc_q    <= 16'h0000;
      cnt_q      <= 2'd0;
      e0_op_q    <= 16'h0000;
      e0_opnd_q  <= 16'h0000;
      e0_pc_q    <= 16'h0000;
      e1_op_q    <= 16'h0000;
      e1_opnd_q  <= 16'h0000;
      e1_pc_q    <= 16'h0000;
      rom_cs_q   <= 1'b0;
      rom_addr_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      discard_q  <= discard_d;
      have_op_q  <= have_op_d;
      op_q       <= op_d;
      op_pc_q    <= op_pc_d;
      cnt_q      <= cnt_d;
      e0_op_q    <= e0_op_d;
      e0_opnd_q  <= e0_opnd_d;
      e0_pc_q    <= e0_pc_d;
      e1_op_q    <= e1_op_d;
      e1_opnd_q  <= e1_opnd_d;
      e1_pc_q    <= e1_pc_d;
      rom_cs_q   <= rom_cs_d;
      rom_addr_q <= rom_addr_d;
    end
  end

  assign rom_cs        = rom_cs_q;
  assign rom_addr      = rom_addr_q;
  assign instr_valid   = (cnt_q != 2'd0);
  assign instr_op      = e0_op_q;
  assign instr_operand = e0_opnd_q;
  assign instr_pc      = e0_pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - bench for instr_fetch: ROM responder, sequential-fetch model, directed scenarios
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rom_cs;
  logic [15:0] rom_addr;
  logic        rom_ready = 1'b1;
  logic [15:0] rom_data = 16'h0000;
  logic        instr_valid;
  logic [15:0] instr_op, instr_operand, instr_pc;
  logic        instr_accept = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;

  int checks = 0;
  int errors = 0;

  logic [15:0] rom_mem [0:4095];
  int          ws = 0;
  int          rom_cnt = 0;
  logic [15:0] rom_lat = 16'h0000;
  logic [15:0] exp_pc = 16'h0000;

  instr_fetch #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst),
    .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_ready(rom_ready), .rom_data(rom_data),
    .instr_valid(instr_valid), .instr_op(instr_op), .instr_operand(instr_operand),
    .instr_pc(instr_pc), .instr_accept(instr_accept),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting", name);
  endtask

  // ROM: sees cs on an edge, drops ready, returns data after ws extra busy cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_ready <= 1'b1;
      rom_cnt   <= 0;
    end else if (rom_cs) begin
      rom_ready <= 1'b0;
      rom_cnt   <= ws;
      rom_lat   <= rom_addr;
    end else if (!rom_ready) begin
      if (rom_cnt == 0) begin
        rom_ready <= 1'b1;
        rom_data  <= rom_mem[rom_lat[11:0]];
      end else begin
        rom_cnt <= rom_cnt - 1;
      end
    end
  end

  // Model: instructions appear in program order from the last start point, two words each.
  initial begin
    logic [15:0] nxt;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_pc = 16'h0000;
      end else begin
        if (!rom_ready) check("rom_addr_hold", rom_addr, rom_lat);
        if (instr_valid) begin
          nxt = exp_pc + 16'd1;
          check("head_pc", instr_pc, exp_pc);
          check("head_op", instr_op, rom_mem[exp_pc[11:0]]);
          check("head_operand", instr_operand, rom_mem[nxt[11:0]]);
        end
        if (redirect) exp_pc = redirect_pc;
        else if (instr_valid && instr_accept) exp_pc = exp_pc + 16'd2;
      end
    end
  end

  task automatic wait_cs(input string name);
    int n = 0;
    while (!rom_cs && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!rom_cs) timeout(name);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!instr_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!instr_valid) timeout(name);
  endtask

  task automatic release_and_measure(input string name);
    int cyc = 0;
    @(posedge clk);
    #2 rst = 1'b0;
    while (!instr_valid && cyc < 30) begin
      @(posedge clk);
      #1 cyc++;
    end
    check(name, cyc, 7);
    check({name, "_op"}, instr_op, 16'h0028);
    check({name, "_operand"}, instr_operand, 16'h0001);
    check({name, "_pc"}, instr_pc, 16'h0000);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 4096; i++) rom_mem[i] = 16'(i * 37) ^ 16'hA5C3;
    rom_mem[0] = 16'h0028; rom_mem[1] = 16'h0001;
    rom_mem[2] = 16'h0034; rom_mem[3] = 16'h7FFD;
    rom_mem[12'hFFE] = 16'h1234; rom_mem[12'hFFF] = 16'h5678;

    #1 rst = 1'b1;
    #2;
    check("reset_cs", rom_cs, 1'b0);
    check("reset_addr", rom_addr, 16'h0000);
    check("reset_valid", instr_valid, 1'b0);
    check("reset_op", instr_op, 16'h0000);
    check("reset_pc", instr_pc, 16'h0000);
    @(posedge clk);
    release_and_measure("first_latency");

    // Decode stalls: two entries fill, fetch parks.
    repeat (30) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("parked_cs", rom_cs, 1'b0);
    end
    check("parked_addr", rom_addr, 16'h0003);
    @(posedge clk); #1 instr_accept = 1'b1;
    @(posedge clk); #1 instr_accept = 1'b0;
    check("second_op", instr_op, 16'h0034);
    check("second_operand", instr_operand, 16'h7FFD);
    check("second_pc", instr_pc, 16'h0002);
    wait_cs("resume_cs");
    check("resume_addr", rom_addr, 16'h0004);

    // Redirect while the operand word at 0007 is in WAIT_HI (ROM stretched by wait states).
    ws = 2;
    @(posedge clk); #1 instr_accept = 1'b1;
    n = 0;
    while (!(rom_cs && rom_addr == 16'h0007) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!(rom_cs && rom_addr == 16'h0007)) timeout("reach_0007");
    @(posedge clk); #1;
    @(posedge clk); #1;
    redirect = 1'b1; redirect_pc = 16'h003B;
    @(posedge clk); #1 redirect = 1'b0;
    wait_cs("redir_cs");
    check("redir_addr", rom_addr, 16'h003B);
    ws = 0;
    repeat (40) @(posedge clk);

    // Redirect coincides with accept while full.
    #1 instr_accept = 1'b0;
    repeat (30) @(posedge clk);
    #1 instr_accept = 1'b1; redirect = 1'b1; redirect_pc = 16'h0100;
    @(posedge clk); #1 instr_accept = 1'b0; redirect = 1'b0;
    check("flush_valid", instr_valid, 1'b0);
    wait_cs("flush_cs");
    check("flush_addr", rom_addr, 16'h0100);

    // Wrap at the top of the address space.
    @(posedge clk); #1 redirect = 1'b1; redirect_pc = 16'hFFFE;
    @(posedge clk); #1 redirect = 1'b0;
    wait_valid("wrap_valid");
    check("wrap_pc", instr_pc, 16'hFFFE);
    check("wrap_op", instr_op, 16'h1234);
    check("wrap_operand", instr_operand, 16'h5678);
    wait_cs("wrap_cs");
    check("wrap_addr", rom_addr, 16'h0000);

    // Asynchronous reset in WAIT_LO.
    @(posedge clk); #2 rst = 1'b1;
    #1;
    check("async_cs", rom_cs, 1'b0);
    check("async_addr", rom_addr, 16'h0000);
    check("async_valid", instr_valid, 1'b0);
    check("async_op", instr_op, 16'h0000);
    check("async_operand", instr_operand, 16'h0000);
    check("async_pc", instr_pc, 16'h0000);
    repeat (2) @(posedge clk);
    release_and_measure("restart_latency");
    repeat (5) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit sitting directly upstream of the program ROM. It drives the ROM's chip-select/address handshake and assembles each two-word instruction (opcode word, then operand word) into one entry. Entries go into a 2-entry buffer and are handed to the decode stage through a valid/accept handshake. Branch redirects from the execute stage flush the buffer and restart fetch at a new PC.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset.
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- rom_cs  output  1  ROM chip select; registered.
- rom_addr  output  16  ROM word address; registered, held stable for the whole ROM transaction.
- rom_ready  input  1  ROM ready (high when idle and when data is valid, low while busy).
- rom_data  input  16  ROM read data; valid only on the cycle rom_ready returns high.
- instr_valid  output  1  buffer head holds a complete instruction.
- instr_op  output  16  opcode word of head entry.
- instr_operand  output  16  operand word of head entry.
- instr_pc  output  16  address of the opcode word of head entry.
- instr_accept  input  1  decode consumes head entry when instr_valid & instr_accept.
- redirect  input  1  one-cycle branch/redirect request.
- redirect_pc  input  16  target address, sampled when redirect=1.

## Operation
- Reset (async, rst=1) forces the following. Internal state is IDLE, pc=RESET_PC and the buffer is empty. rom_cs=0, rom_addr=0, instr_valid=0, instr_op/instr_operand/instr_pc=0, and the discard flag is cleared.
- FSM states:
  - IDLE:
    - Go to REQ when the buffer has a free slot and no redirect is present.
    - Otherwise stay in IDLE.
  - REQ:
    - rom_cs=1 and rom_addr=pc for exactly one cycle.
    - Always go to WAIT_LO.
  - WAIT_LO:
    - rom_cs=0.
    - Stay until rom_ready=0 is sampled, then go to WAIT_HI.
  - WAIT_HI:
    - Stay until rom_ready=1 is sampled.
    - On that edge, capture rom_data and increment pc (16-bit wrap, FFFF -> 0000).
    - If the captured word is the opcode word, hold it and go to REQ for the operand word.
    - If it is the operand word, write {op, operand, opcode pc} into the buffer tail.
    - After writing an operand word, go to REQ if the buffer still has a free slot, else IDLE.
- Buffer:
  - 2-entry FIFO; the head drives the instr_* outputs.
  - A push and a pop on the same edge are both performed.
  - Count never exceeds 2; no push is ever attempted when full.
- Redirect:
  - redirect=1 flushes the buffer and any half-assembled opcode on the same edge, and loads pc=redirect_pc.
  - The ROM transaction cannot be aborted. If the FSM is in WAIT_LO or WAIT_HI, it sets discard.
  - With discard set, the FSM finishes the handshake, drops the captured word, does not increment pc, clears discard, then goes to REQ.
  - In IDLE or REQ, a redirect takes effect immediately. A REQ already issued counts as in flight: the FSM goes to WAIT_LO with discard set.
- Redirect together with accept on the same edge: the redirect wins, the buffer ends empty and the accept is void.
- A second redirect while discard is already set reloads pc only; discard stays set.
- rom_addr[15:12] are driven from pc as-is. The ROM decodes only [11:0], so addresses alias.

## Timing
- ROM word cycle: REQ edge n. The ROM sees cs at edge n+1, ready goes low. At edge n+2 the FSM samples ready=0. At edge n+3 it samples ready=1 and captures data. This is 3 cycles per word when no extra wait states occur.
- Instruction latency from reset release or redirect to instr_valid=1 is 7 cycles: 1 (IDLE->REQ) + 3 + 3.
- Steady-state throughput is one instruction per 6 cycles.
- instr_valid and the head fields are registered. They change only on the edge after a push into an empty buffer, a pop, or a flush.
- The head is stable while instr_valid=1 and instr_accept=0.
- rom_addr is never changed while in WAIT_LO or WAIT_HI.

## Test plan
- Reset release with ROM[0..3]=0028,0001,0034,7FFD:
  - instr_valid rises 7 cycles after reset release, with op=0028, operand=0001, pc=0000.
  - After accept, the next entry is op=0034, operand=7FFD, pc=0002.
- Decode never accepts:
  - Two entries buffer, then the FSM parks in IDLE with rom_cs=0.
  - After one accept, fetch resumes at pc=0004.
- Redirect to 003B asserted during WAIT_HI of an operand fetch:
  - The ROM handshake completes and the word is discarded.
  - The next rom_addr issued is 003B, and no stale instruction ever appears.
- Redirect on the same edge as accept with 2 entries buffered:
  - The buffer is empty next cycle (instr_valid=0) and pc=redirect_pc.
- Wrap: redirect to FFFE:
  - The entry has pc=FFFE and the next fetch address is 0000.
- rst asserted mid-WAIT_LO:
  - Outputs clear immediately, with no clock needed.
  - After release, fetch restarts at RESET_PC.
